// File: rtl/paddle_pos_ctrl_if.sv
// Bundles the control, potentiometer and position signals of paddle_pos_ctrl.
// The controller drives the master side; paddle_pos_ctrl is the slave.
interface paddle_pos_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int POT_W  = 8,
  parameter int POS_W  = 10
);
  logic                    enable;
  logic                    recenter;
  logic [NUM_CH-1:0]       invert_mask;
  logic [NUM_CH*POT_W-1:0] pot_in;
  logic [NUM_CH*POS_W-1:0] pos_out;
  logic                    pos_valid;
  logic                    busy;

  modport master (
    output enable, recenter, invert_mask, pot_in,
    input  pos_out, pos_valid, busy
  );

  modport slave (
    input  enable, recenter, invert_mask, pot_in,
    output pos_out, pos_valid, busy
  );
endinterface

// File: rtl/paddle_pos_ctrl.sv
// Turns NUM_CH potentiometer readings into clamped, dead-banded, slew-limited paddle
// positions, one channel per cycle after each periodic tick.
module paddle_pos_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int POT_W    = 8,
  parameter int POS_W    = 10,
  parameter int SHIFT    = 1,
  parameter int OFFSET   = 41,
  parameter int POS_MAX  = 430,
  parameter int MAX_STEP = 16,
  parameter int DEADBAND = 2,
  parameter int TICK_W   = 20
) (
  input  logic             clk,
  input  logic             reset,
  paddle_pos_ctrl_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW   = (((POT_W + SHIFT) > POS_W) ? (POT_W + SHIFT) : POS_W) + 1;

  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [POS_W-1:0] CENTER     = POS_W'(POS_MAX >> 1);
  localparam logic [IW-1:0]    OFFSET_W   = IW'(OFFSET);
  localparam logic [IW-1:0]    POS_MAX_W  = IW'(POS_MAX);
  localparam logic [IW-1:0]    STEP_W     = IW'(MAX_STEP);
  localparam logic [IW-1:0]    DEADBAND_W = IW'(DEADBAND);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [TICK_W-1:0]       tick_cnt_q;
  logic [CH_W-1:0]         ch_q;
  logic [NUM_CH*POT_W-1:0] sample_q;
  logic [NUM_CH*POS_W-1:0] pos_q;
  logic                    tick;

  logic [POT_W-1:0] pot_sel;
  logic [IW-1:0]    raw, target, pos_cur, diff;
  logic [POS_W-1:0] pos_next;

  assign tick        = bus.enable & (&tick_cnt_q);
  assign bus.pos_out = pos_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (bus.recenter) begin
      tick_cnt_q <= '0;
    end else if (bus.enable) begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (bus.recenter) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = SCAN;
      SCAN:    if (ch_q == LAST_CH) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.pos_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      SCAN:    bus.busy = 1'b1;
      DONE: begin
        bus.busy      = 1'b1;
        bus.pos_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Channel arithmetic for the channel currently being scanned.
  always_comb begin
    pot_sel = sample_q[int'(ch_q)*POT_W +: POT_W];
    if (bus.invert_mask[ch_q]) pot_sel = ~pot_sel;
    raw = IW'(pot_sel) << SHIFT;

    if (raw < OFFSET_W)                target = '0;
    else if (raw - OFFSET_W > POS_MAX_W) target = POS_MAX_W;
    else                               target = raw - OFFSET_W;

    pos_cur = IW'(pos_q[int'(ch_q)*POS_W +: POS_W]);
    diff    = (target >= pos_cur) ? (target - pos_cur) : (pos_cur - target);

    // Stepping toward target from an in-range position never leaves [0, POS_MAX].
    if (diff <= DEADBAND_W)                   pos_next = POS_W'(pos_cur);
    else if (MAX_STEP == 0 || diff <= STEP_W) pos_next = POS_W'(target);
    else if (target > pos_cur)                pos_next = POS_W'(pos_cur + STEP_W);
    else                                      pos_next = POS_W'(pos_cur - STEP_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q     <= '0;
      sample_q <= '0;
      pos_q    <= '0;
    end else if (bus.recenter) begin
      ch_q  <= '0;
      pos_q <= {NUM_CH{CENTER}};
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            sample_q <= bus.pot_in;
            ch_q     <= '0;
          end
        end
        SCAN: begin
          pos_q[int'(ch_q)*POS_W +: POS_W] <= pos_next;
          if (ch_q != LAST_CH) ch_q <= ch_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_pos_ctrl.sv
// Directed bench: one unit without slew/dead-band limits, one with defaults (step 16, band 2).
module tb_paddle_pos_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       recenter;
  logic [1:0] inv;
  logic [7:0] pot0, pot1;

  int n_cmp  = 0;
  int n_fail = 0;

  paddle_pos_ctrl_if #(.NUM_CH(2), .POT_W(8), .POS_W(10)) bus_a ();
  paddle_pos_ctrl_if #(.NUM_CH(2), .POT_W(8), .POS_W(10)) bus_b ();

  assign bus_a.enable      = enable;
  assign bus_a.recenter    = recenter;
  assign bus_a.invert_mask = inv;
  assign bus_a.pot_in      = {pot1, pot0};
  assign bus_b.enable      = enable;
  assign bus_b.recenter    = recenter;
  assign bus_b.invert_mask = inv;
  assign bus_b.pot_in      = {pot1, pot0};

  paddle_pos_ctrl #(.TICK_W(4), .MAX_STEP(0), .DEADBAND(0)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  paddle_pos_ctrl #(.TICK_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the negedge where pos_valid pulses; bounded.
  task automatic wait_valid(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_b.pos_valid) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_valid_seen"}, 32'(found), 1);
  endtask

  // Count negedges until busy rises, noting any pos_valid on the way; bounded.
  task automatic wait_busy(input string tag, output int cycles, output logic valid_seen);
    logic found = 1'b0;
    cycles     = 0;
    valid_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (bus_b.pos_valid || bus_a.pos_valid) valid_seen = 1'b1;
      if (bus_b.busy) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_busy_seen"}, 32'(found), 1);
  endtask

  initial begin
    int   cyc;
    logic vseen;
    int   n_upd;
    int   exp_v;

    // 1. Reset state and first-tick latency
    reset = 1'b1; enable = 1'b0; recenter = 1'b0; inv = 2'b00;
    pot0 = 8'h10; pot1 = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_pos_b",   32'(bus_b.pos_out), 0);
    check("rst_pos_a",   32'(bus_a.pos_out), 0);
    check("rst_valid",   32'(bus_b.pos_valid), 0);
    check("rst_busy",    32'(bus_b.busy), 0);
    reset = 1'b0; enable = 1'b1;

    wait_busy("first_tick", cyc, vseen);
    check("first_tick_cycles", 32'(cyc), 16);
    check("lat_c1_valid", 32'(bus_b.pos_valid), 0);
    @(negedge clk);
    check("lat_c2_busy",  32'(bus_b.busy), 1);
    check("lat_c2_valid", 32'(bus_b.pos_valid), 0);
    @(negedge clk);
    check("lat_c3_busy",  32'(bus_b.busy), 1);
    check("lat_c3_valid", 32'(bus_b.pos_valid), 1);
    check("lat_c3_valid_a", 32'(bus_a.pos_valid), 1);
    // 2. Unlimited unit: 0x10 -> 0, 0xFF -> 430; limited unit starts stepping
    check("u1_a_pos0", 32'(bus_a.pos_out[9:0]), 0);
    check("u1_a_pos1", 32'(bus_a.pos_out[19:10]), 430);
    check("u1_b_pos0", 32'(bus_b.pos_out[9:0]), 0);
    check("u1_b_pos1", 32'(bus_b.pos_out[19:10]), 16);
    @(negedge clk);
    check("lat_c4_busy",  32'(bus_b.busy), 0);
    check("lat_c4_valid", 32'(bus_b.pos_valid), 0);
    n_upd = 1;

    // 3. Slew limit: pot0=0x80 (target 215)
    pot0 = 8'h80;
    for (int k = 1; k <= 13; k++) begin
      wait_valid("slew");
      n_upd++;
      check("slew_b_pos0", 32'(bus_b.pos_out[9:0]), 32'(16 * k));
      exp_v = (16 * n_upd > 430) ? 430 : 16 * n_upd;
      check("slew_b_pos1", 32'(bus_b.pos_out[19:10]), 32'(exp_v));
      if (k == 1) check("u2_a_pos0", 32'(bus_a.pos_out[9:0]), 215);
    end
    wait_valid("slew_final");
    check("slew_final_pos0", 32'(bus_b.pos_out[9:0]), 215);
    wait_valid("slew_hold");
    check("slew_hold_pos0", 32'(bus_b.pos_out[9:0]), 215);

    // 4. Dead-band: 0x81 -> 217 (d=2, held), 0x82 -> 219 (d=4, moves)
    pot0 = 8'h81;
    wait_valid("db_in");
    check("db_in_b_pos0", 32'(bus_b.pos_out[9:0]), 215);
    check("db_in_a_pos0", 32'(bus_a.pos_out[9:0]), 217);
    pot0 = 8'h82;
    wait_valid("db_out");
    check("db_out_b_pos0", 32'(bus_b.pos_out[9:0]), 219);
    check("db_out_a_pos0", 32'(bus_a.pos_out[9:0]), 219);
    check("u18_b_pos1",    32'(bus_b.pos_out[19:10]), 288);

    // 5. Invert channel 1: pot1=0x00 reads as 0xFF (target 430)
    inv = 2'b10; pot1 = 8'h00;
    for (int j = 1; j <= 9; j++) begin
      wait_valid("inv_up");
      exp_v = (288 + 16 * j > 430) ? 430 : 288 + 16 * j;
      check("inv_up_b_pos1", 32'(bus_b.pos_out[19:10]), 32'(exp_v));
    end
    check("inv_up_a_pos1", 32'(bus_a.pos_out[19:10]), 430);
    pot1 = 8'hFF;
    for (int j = 1; j <= 27; j++) begin
      wait_valid("inv_dn");
      exp_v = (430 - 16 * j < 0) ? 0 : 430 - 16 * j;
      check("inv_dn_b_pos1", 32'(bus_b.pos_out[19:10]), 32'(exp_v));
      if (j == 1) check("inv_dn_a_pos1", 32'(bus_a.pos_out[19:10]), 0);
    end
    check("inv_dn_b_pos0", 32'(bus_b.pos_out[9:0]), 219);

    // 6a. Recenter during a scan
    wait_busy("rc_scan", cyc, vseen);
    recenter = 1'b1;
    @(negedge clk);
    recenter = 1'b0;
    check("rc_b_pos",   32'(bus_b.pos_out), 32'({10'd215, 10'd215}));
    check("rc_a_pos",   32'(bus_a.pos_out), 32'({10'd215, 10'd215}));
    check("rc_busy",    32'(bus_b.busy), 0);
    check("rc_valid",   32'(bus_b.pos_valid), 0);
    wait_busy("rc_next", cyc, vseen);
    check("rc_no_valid",     32'(vseen), 0);
    check("rc_next_cycles",  32'(cyc), 16);
    wait_valid("rc_update");
    check("rc_upd_b_pos0", 32'(bus_b.pos_out[9:0]), 219);
    check("rc_upd_b_pos1", 32'(bus_b.pos_out[19:10]), 199);
    check("rc_upd_a_pos1", 32'(bus_a.pos_out[19:10]), 0);

    // 6b. Reset mid-scan clears asynchronously
    wait_busy("rst_scan", cyc, vseen);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_b_pos", 32'(bus_b.pos_out), 0);
    check("mid_rst_a_pos", 32'(bus_a.pos_out), 0);
    check("mid_rst_busy",  32'(bus_b.busy), 0);
    check("mid_rst_valid", 32'(bus_b.pos_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(bus_b.busy), 0);
    check("post_rst_pos",  32'(bus_b.pos_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
